enigma_arb: RTL and testbench
=============================

ENIGMA_ARB -- requirements
Module: enigma_arb

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 8, consecutive lost arbitrations after which an eligible port is forced to win.
REQ-002 SHALL have parameter RETRY_GAP, default 2, idle cycles valid_c stays low after a conflicted handshake (range 1..15).
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 payload_a / id_a / qos_a / valid_a  input  128/5/2/1  port A request beat.
REQ-006 ready_a  output  1  port A beat accepted this cycle.
REQ-007 payload_b / id_b / qos_b / valid_b  input  128/5/2/1  port B request beat.
REQ-008 ready_b  output  1  port B beat accepted this cycle.
REQ-009 payload_c / id_c / qos_c / valid_c  output  128/6/2/1  merged beat; id_c = {src, id}, src 0 = A, 1 = B.
REQ-010 ready_c  input  1  downstream accepts beat.
REQ-011 conflict_c  input  1  downstream rejects the beat handshaked this cycle.
REQ-012 release_c / releaseid_c  input  1/6  downstream retires outstanding id releaseid_c.
REQ-013 err_release  output  1  sticky: release received for non-outstanding id.

Function
REQ-014 Handshake on C (valid_c & ready_c) SHALL be "accepted" when conflict_c=0, "conflicted" when conflict_c=1.
REQ-015 C SHALL be driven from one output register; valid_c, once high, SHALL hold payload/id/qos stable until accepted or conflicted.
REQ-016 Output register SHALL load when empty or accepted this cycle, and not in RETRY state.
REQ-017 Port X eligible iff valid_x=1, outstanding[{X,id_x}]=0, and {X,id_x} differs from id_c while valid_c=1.
REQ-018 Winner: higher qos; qos tie -> round-robin pointer; starvation override beats qos.
REQ-019 ready_x SHALL be 1 only in a load cycle for the winner; ready_a and ready_b never both 1; combinational on valid_x permitted.
REQ-020 Latency: beat accepted on A/B in cycle N SHALL appear on C with valid_c=1 in cycle N+1.
REQ-021 Round-robin pointer SHALL move to the non-winner after every qos-tie grant.
REQ-022 Per-port starvation counter SHALL increment when port eligible and loses, clear on its grant, saturate at STARVE_MAX; counter = STARVE_MAX forces win next load.
REQ-023 Both counters at STARVE_MAX: round-robin pointer decides.
REQ-024 Outstanding table: 64 bits; set for id_c on accepted handshake; cleared by release_c.
REQ-025 Set and clear of same id in same cycle: set SHALL win.
REQ-026 release_c for clear bit SHALL set err_release; no table change.
REQ-027 Conflicted handshake: table unchanged, register retained, FSM -> RETRY, valid_c=0 for RETRY_GAP cycles, then same beat re-presented.
REQ-028 FSM states IDLE (register empty), HOLD (valid_c=1), RETRY (gap counting); IDLE->HOLD on load; HOLD->IDLE on accept with no load; HOLD->HOLD on accept with load; HOLD->RETRY on conflict; RETRY->HOLD when gap counter expires.
REQ-029 conflict_c and release_c outside handshake (for conflict) SHALL be ignored / processed independently respectively.

Reset
REQ-030 On rst_n=0: valid_c=0, payload_c=0, id_c=0, qos_c=0, ready_a=ready_b=0, err_release=0, table cleared, counters 0, pointer = A, FSM IDLE.
REQ-031 Reset mid-transfer SHALL drop any held or retrying beat without handshake.

Structure
REQ-032 Package enigma_pkg SHALL hold beat typedef (payload,id,qos), ID width constants (5 in, 6 out), FSM state enum.
REQ-033 Outstanding table SHALL be sub-module enigma_id_table (set, clear, two lookup ports, err flag).

Verification
REQ-034 A only, qos 1, id 3, ready_c=1 -> valid_c next cycle, id_c=0x03; bit 3 outstanding; second A id 3 stalled until release_c id 3.
REQ-035 A qos 3, B qos 1 continuous -> A wins; B granted on 9th load (STARVE_MAX=8).
REQ-036 A, B both qos 2, distinct ids -> grants alternate A,B,A,B.
REQ-037 conflict_c=1 on first handshake -> valid_c low 2 cycles, same beat re-presented, table bit set only after accept.
REQ-038 release_c id 0x25 never issued -> err_release=1 and stays until reset; assert rst_n=0 while valid_c=1 -> all outputs 0.

Source files
------------

// File: rtl/enigma_pkg.sv
// Shared types and constants for the enigma two-port merging arbiter.
// A beat carries payload, merged source/id and qos; ids widen by one source bit.
package enigma_pkg;

  localparam int PAYLOAD_W   = 128;
  localparam int ID_IN_W     = 5;
  localparam int ID_OUT_W    = 6;
  localparam int QOS_W       = 2;
  localparam int TABLE_DEPTH = 64;
  localparam int GAP_W       = 4;

  typedef struct packed {
    logic [PAYLOAD_W-1:0] payload;
    logic [ID_OUT_W-1:0]  id;
    logic [QOS_W-1:0]     qos;
  } beat_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_RETRY = 2'd2
  } state_t;

  // Source bit 0 = port A, 1 = port B, prepended to the port-local id.
  function automatic logic [ID_OUT_W-1:0] merge_id(input logic src,
                                                   input logic [ID_IN_W-1:0] id);
    return {src, id};
  endfunction

endpackage

// File: rtl/enigma_id_table.sv
// Outstanding-id scoreboard: one bit per merged id, set on accepted beats,
// cleared on release, with a sticky flag for releases of ids not outstanding.
module enigma_id_table
  import enigma_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                set_en,
  input  logic [ID_OUT_W-1:0] set_id,
  input  logic                clr_en,
  input  logic [ID_OUT_W-1:0] clr_id,
  input  logic [ID_OUT_W-1:0] look_a_id,
  input  logic [ID_OUT_W-1:0] look_b_id,
  output logic                hit_a,
  output logic                hit_b,
  output logic                err
);

  logic [TABLE_DEPTH-1:0] bits_r;
  logic [TABLE_DEPTH-1:0] bits_nxt_s;
  logic                   err_r;
  logic                   err_nxt_s;

  // Clear is applied before set so a same-cycle set of the same id wins.
  always_comb begin
    bits_nxt_s = bits_r;
    err_nxt_s  = err_r;
    if (clr_en) begin
      if (bits_r[clr_id]) begin
        bits_nxt_s[clr_id] = 1'b0;
      end else begin
        err_nxt_s = 1'b1;
      end
    end else begin
      err_nxt_s = err_r;
    end
    if (set_en) begin
      bits_nxt_s[set_id] = 1'b1;
    end else begin
      bits_nxt_s = bits_nxt_s;
    end
  end

  // Table and sticky error state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bits_r <= '0;
      err_r  <= 1'b0;
    end else begin
      bits_r <= bits_nxt_s;
      err_r  <= err_nxt_s;
    end
  end

  assign hit_a = bits_r[look_a_id];
  assign hit_b = bits_r[look_b_id];
  assign err   = err_r;

endmodule

// File: rtl/enigma_arb.sv
// Two-port qos/round-robin arbiter with starvation override, merging A and B
// into one registered output channel with id tracking and conflict retry.
module enigma_arb
  import enigma_pkg::*;
#(
  parameter int STARVE_MAX = 8,
  parameter int RETRY_GAP  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [PAYLOAD_W-1:0] payload_a,
  input  logic [ID_IN_W-1:0]   id_a,
  input  logic [QOS_W-1:0]     qos_a,
  input  logic                 valid_a,
  output logic                 ready_a,
  input  logic [PAYLOAD_W-1:0] payload_b,
  input  logic [ID_IN_W-1:0]   id_b,
  input  logic [QOS_W-1:0]     qos_b,
  input  logic                 valid_b,
  output logic                 ready_b,
  output logic [PAYLOAD_W-1:0] payload_c,
  output logic [ID_OUT_W-1:0]  id_c,
  output logic [QOS_W-1:0]     qos_c,
  output logic                 valid_c,
  input  logic                 ready_c,
  input  logic                 conflict_c,
  input  logic                 release_c,
  input  logic [ID_OUT_W-1:0]  releaseid_c,
  output logic                 err_release
);

  localparam int               SW         = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0]    STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [GAP_W-1:0] GAP_LOAD   = GAP_W'(RETRY_GAP - 1);

  state_t            state_r, state_nxt_s;
  beat_t             out_r, out_nxt_s;
  logic              valid_r, valid_nxt_s;
  logic [GAP_W-1:0]  gap_r, gap_nxt_s;
  logic              ptr_r, ptr_nxt_s;
  logic [SW-1:0]     starve_a_r, starve_a_nxt_s;
  logic [SW-1:0]     starve_b_r, starve_b_nxt_s;

  beat_t             beat_a_s, beat_b_s;
  logic              hit_a_s, hit_b_s;
  logic              hs_s, acc_s, conf_s;
  logic              load_ok_s, grant_s;
  logic              elig_a_s, elig_b_s;
  logic              force_a_s, force_b_s;
  logic              win_b_s, rr_used_s;

  assign beat_a_s = '{payload: payload_a, id: merge_id(1'b0, id_a), qos: qos_a};
  assign beat_b_s = '{payload: payload_b, id: merge_id(1'b1, id_b), qos: qos_b};

  assign hs_s   = valid_r & ready_c;
  assign acc_s  = hs_s & ~conflict_c;
  assign conf_s = hs_s & conflict_c;

  assign load_ok_s = (state_r == ST_IDLE) | ((state_r == ST_HOLD) & acc_s);

  // The beat currently on C blocks its own id even before it is outstanding.
  assign elig_a_s = valid_a & ~hit_a_s & ~(valid_r & (out_r.id == beat_a_s.id));
  assign elig_b_s = valid_b & ~hit_b_s & ~(valid_r & (out_r.id == beat_b_s.id));

  assign force_a_s = elig_a_s & (starve_a_r == STARVE_LIM);
  assign force_b_s = elig_b_s & (starve_b_r == STARVE_LIM);

  enigma_id_table u_table (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_en    (acc_s),
    .set_id    (out_r.id),
    .clr_en    (release_c),
    .clr_id    (releaseid_c),
    .look_a_id (beat_a_s.id),
    .look_b_id (beat_b_s.id),
    .hit_a     (hit_a_s),
    .hit_b     (hit_b_s),
    .err       (err_release)
  );

  // Winner select: starvation override, then qos, then round-robin pointer.
  always_comb begin
    win_b_s   = 1'b0;
    rr_used_s = 1'b0;
    if (elig_a_s & elig_b_s) begin
      if (force_a_s != force_b_s) begin
        win_b_s = force_b_s;
      end else if (!force_a_s && (qos_a != qos_b)) begin
        win_b_s = (qos_b > qos_a);
      end else begin
        win_b_s   = ptr_r;
        rr_used_s = 1'b1;
      end
    end else begin
      win_b_s = elig_b_s;
    end
  end

  assign grant_s = load_ok_s & (elig_a_s | elig_b_s);
  assign ready_a = rst_n & grant_s & ~win_b_s;
  assign ready_b = rst_n & grant_s & win_b_s;

  // Pointer and per-port starvation counters.
  always_comb begin
    ptr_nxt_s      = ptr_r;
    starve_a_nxt_s = starve_a_r;
    starve_b_nxt_s = starve_b_r;
    if (grant_s) begin
      if (rr_used_s) begin
        ptr_nxt_s = ~win_b_s;
      end else begin
        ptr_nxt_s = ptr_r;
      end
      if (win_b_s) begin
        starve_b_nxt_s = '0;
        if (elig_a_s && (starve_a_r != STARVE_LIM)) begin
          starve_a_nxt_s = starve_a_r + SW'(1);
        end else begin
          starve_a_nxt_s = starve_a_r;
        end
      end else begin
        starve_a_nxt_s = '0;
        if (elig_b_s && (starve_b_r != STARVE_LIM)) begin
          starve_b_nxt_s = starve_b_r + SW'(1);
        end else begin
          starve_b_nxt_s = starve_b_r;
        end
      end
    end else begin
      ptr_nxt_s = ptr_r;
    end
  end

  // Output-channel FSM and output register load.
  always_comb begin
    state_nxt_s = state_r;
    gap_nxt_s   = gap_r;
    out_nxt_s   = out_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_s) begin
          state_nxt_s = ST_HOLD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (conf_s) begin
          state_nxt_s = ST_RETRY;
          gap_nxt_s   = GAP_LOAD;
        end else if (acc_s) begin
          state_nxt_s = grant_s ? ST_HOLD : ST_IDLE;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      ST_RETRY: begin
        if (gap_r == {GAP_W{1'b0}}) begin
          state_nxt_s = ST_HOLD;
        end else begin
          gap_nxt_s = gap_r - GAP_W'(1);
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        gap_nxt_s   = '0;
      end
    endcase
    if (grant_s) begin
      out_nxt_s = win_b_s ? beat_b_s : beat_a_s;
    end else begin
      out_nxt_s = out_r;
    end
    valid_nxt_s = (state_nxt_s == ST_HOLD);
  end

  // State registers; reset drops any held or retrying beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      out_r      <= '0;
      valid_r    <= 1'b0;
      gap_r      <= '0;
      ptr_r      <= 1'b0;
      starve_a_r <= '0;
      starve_b_r <= '0;
    end else begin
      state_r    <= state_nxt_s;
      out_r      <= out_nxt_s;
      valid_r    <= valid_nxt_s;
      gap_r      <= gap_nxt_s;
      ptr_r      <= ptr_nxt_s;
      starve_a_r <= starve_a_nxt_s;
      starve_b_r <= starve_b_nxt_s;
    end
  end

  assign payload_c = out_r.payload;
  assign id_c      = out_r.id;
  assign qos_c     = out_r.qos;
  assign valid_c   = valid_r;

endmodule

// File: tb/tb_enigma_arb.sv
// Self-checking bench for enigma_arb: directed scenarios plus a randomized run
// compared cycle by cycle against a behavioural reference model.
module tb_enigma_arb;

  localparam int STARVE_MAX = 8;
  localparam int RETRY_GAP  = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [127:0] payload_a, payload_b, payload_c;
  logic [4:0]   id_a, id_b;
  logic [1:0]   qos_a, qos_b, qos_c;
  logic         valid_a, valid_b, ready_a, ready_b;
  logic [5:0]   id_c, releaseid_c;
  logic         valid_c, ready_c, conflict_c, release_c, err_release;

  int n_tests = 0;
  int n_fail  = 0;

  enigma_arb #(.STARVE_MAX(STARVE_MAX), .RETRY_GAP(RETRY_GAP)) dut (
    .clk(clk), .rst_n(rst_n),
    .payload_a(payload_a), .id_a(id_a), .qos_a(qos_a), .valid_a(valid_a), .ready_a(ready_a),
    .payload_b(payload_b), .id_b(id_b), .qos_b(qos_b), .valid_b(valid_b), .ready_b(ready_b),
    .payload_c(payload_c), .id_c(id_c), .qos_c(qos_c), .valid_c(valid_c),
    .ready_c(ready_c), .conflict_c(conflict_c), .release_c(release_c),
    .releaseid_c(releaseid_c), .err_release(err_release)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic idle_inputs();
    payload_a = '0; id_a = '0; qos_a = '0; valid_a = 1'b0;
    payload_b = '0; id_b = '0; qos_b = '0; valid_b = 1'b0;
    ready_c = 1'b0; conflict_c = 1'b0; release_c = 1'b0; releaseid_c = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    #2;
    rst_n = 1'b0;
    valid_a = 1'b1; id_a = 5'd1; qos_a = 2'd1;
    repeat (2) @(negedge clk);
    n_tests++;
    if (valid_c !== 1'b0 || payload_c !== 128'd0 || id_c !== 6'd0 || qos_c !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_c: valid=%b id=%h qos=%h payload=%h, required all zero",
               valid_c, id_c, qos_c, payload_c);
    end
    n_tests++;
    if (ready_a !== 1'b0 || ready_b !== 1'b0 || err_release !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready: ready_a=%b ready_b=%b err=%b, required 0 0 0",
               ready_a, ready_b, err_release);
    end
    valid_a = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_a();
    logic [127:0] p1, p2;
    p1 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    p2 = 128'hA5A5_0000_FFFF_1234_0000_BEEF_CAFE_0001;
    do_reset();
    next_cycle();
    ready_c = 1'b1; valid_a = 1'b1; id_a = 5'd3; qos_a = 2'd1; payload_a = p1;
    @(negedge clk);
    n_tests++;
    if (ready_a !== 1'b1 || ready_b !== 1'b0) begin
      n_fail++;
      $display("FAIL single_grant: ready_a=%b ready_b=%b, required 1 0", ready_a, ready_b);
    end
    next_cycle();
    payload_a = p2;
    @(negedge clk);
    n_tests++;
    if (valid_c !== 1'b1 || id_c !== 6'h03 || qos_c !== 2'd1 || payload_c !== p1) begin
      n_fail++;
      $display("FAIL single_out: valid=%b id=%h qos=%h payload=%h, required 1 03 1 %h",
               valid_c, id_c, qos_c, payload_c, p1);
    end
    n_tests++;
    if (ready_a !== 1'b0) begin
      n_fail++;
      $display("FAIL single_same_id_on_c: ready_a=%b, required 0", ready_a);
    end
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      @(negedge clk);
      n_tests++;
      if (ready_a !== 1'b0 || valid_c !== 1'b0) begin
        n_fail++;
        $display("FAIL single_stall: cycle %0d ready_a=%b valid_c=%b, required 0 0",
                 k, ready_a, valid_c);
      end
    end
    next_cycle();
    release_c = 1'b1; releaseid_c = 6'h03;
    @(negedge clk);
    n_tests++;
    if (ready_a !== 1'b0) begin
      n_fail++;
      $display("FAIL single_release_cycle: ready_a=%b, required 0", ready_a);
    end
    next_cycle();
    release_c = 1'b0;
    @(negedge clk);
    n_tests++;
    if (ready_a !== 1'b1) begin
      n_fail++;
      $display("FAIL single_after_release: ready_a=%b, required 1", ready_a);
    end
    next_cycle();
    valid_a = 1'b0;
    @(negedge clk);
    n_tests++;
    if (valid_c !== 1'b1 || payload_c !== p2 || err_release !== 1'b0) begin
      n_fail++;
      $display("FAIL single_second_beat: valid=%b payload=%h err=%b, required 1 %h 0",
               valid_c, payload_c, err_release, p2);
    end
  endtask

  task automatic test_starvation();
    int loads, first_b;
    loads = 0; first_b = 0;
    do_reset();
    for (int k = 0; k < 12; k++) begin
      next_cycle();
      ready_c = 1'b1;
      valid_a = 1'b1; qos_a = 2'd3; id_a = 5'(k); payload_a = 128'(k);
      valid_b = 1'b1; qos_b = 2'd1; id_b = 5'd20; payload_b = 128'hB;
      @(negedge clk);
      if (ready_a || ready_b) loads++;
      if (ready_b && first_b == 0) first_b = loads;
    end
    n_tests++;
    if (first_b !== 9) begin
      n_fail++;
      $display("FAIL starve_first_b: B first granted on load %0d, required 9", first_b);
    end
    n_tests++;
    if (loads !== 12) begin
      n_fail++;
      $display("FAIL starve_loads: %0d loads in 12 cycles, required 12", loads);
    end
  endtask

  task automatic test_tie_alternate();
    int w [4];
    int exp_w [4];
    exp_w = '{0, 1, 0, 1};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      ready_c = 1'b1;
      valid_a = 1'b1; qos_a = 2'd2; id_a = 5'(k + 1);
      valid_b = 1'b1; qos_b = 2'd2; id_b = 5'(k + 1);
      @(negedge clk);
      w[k] = ready_b ? 1 : (ready_a ? 0 : 2);
    end
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (w[k] !== exp_w[k]) begin
        n_fail++;
        $display("FAIL tie_grant%0d: winner %0d, required %0d (0=A 1=B 2=none)",
                 k, w[k], exp_w[k]);
      end
    end
  endtask

  task automatic test_conflict();
    logic [127:0] p;
    p = 128'hC0FF_EE00_0000_0000_0000_0000_DEAD_0005;
    do_reset();
    next_cycle();
    ready_c = 1'b1; conflict_c = 1'b1;
    valid_a = 1'b1; id_a = 5'd5; qos_a = 2'd1; payload_a = p;
    @(negedge clk);
    n_tests++;
    if (ready_a !== 1'b1) begin
      n_fail++;
      $display("FAIL conflict_grant: ready_a=%b, required 1", ready_a);
    end
    next_cycle();
    valid_a = 1'b0;
    @(negedge clk);
    n_tests++;
    if (valid_c !== 1'b1 || id_c !== 6'h05) begin
      n_fail++;
      $display("FAIL conflict_first: valid=%b id=%h, required 1 05", valid_c, id_c);
    end
    for (int k = 0; k < RETRY_GAP; k++) begin
      next_cycle();
      conflict_c = 1'b0;
      valid_a = 1'b1; id_a = 5'd6; payload_a = 128'd6;
      @(negedge clk);
      n_tests++;
      if (valid_c !== 1'b0 || ready_a !== 1'b0) begin
        n_fail++;
        $display("FAIL conflict_gap%0d: valid_c=%b ready_a=%b, required 0 0",
                 k, valid_c, ready_a);
      end
    end
    next_cycle();
    valid_a = 1'b0;
    @(negedge clk);
    n_tests++;
    if (valid_c !== 1'b1 || id_c !== 6'h05 || payload_c !== p || qos_c !== 2'd1) begin
      n_fail++;
      $display("FAIL conflict_represent: valid=%b id=%h payload=%h, required 1 05 %h",
               valid_c, id_c, payload_c, p);
    end
    next_cycle();
    valid_a = 1'b1; id_a = 5'd5;
    @(negedge clk);
    n_tests++;
    if (ready_a !== 1'b0) begin
      n_fail++;
      $display("FAIL conflict_outstanding: ready_a=%b, required 0", ready_a);
    end
    next_cycle();
    valid_a = 1'b0; release_c = 1'b1; releaseid_c = 6'h05;
    next_cycle();
    release_c = 1'b0;
    @(negedge clk);
    n_tests++;
    if (err_release !== 1'b0) begin
      n_fail++;
      $display("FAIL conflict_release_ok: err_release=%b, required 0", err_release);
    end
  endtask

  task automatic test_err_and_reset();
    do_reset();
    next_cycle();
    release_c = 1'b1; releaseid_c = 6'h25;
    next_cycle();
    release_c = 1'b0;
    @(negedge clk);
    n_tests++;
    if (err_release !== 1'b1) begin
      n_fail++;
      $display("FAIL err_set: err_release=%b, required 1", err_release);
    end
    repeat (3) next_cycle();
    valid_b = 1'b1; id_b = 5'd7; qos_b = 2'd2; payload_b = 128'h77;
    next_cycle();
    valid_b = 1'b0;
    @(negedge clk);
    n_tests++;
    if (err_release !== 1'b1 || valid_c !== 1'b1 || id_c !== 6'h27) begin
      n_fail++;
      $display("FAIL err_sticky_hold: err=%b valid=%b id=%h, required 1 1 27",
               err_release, valid_c, id_c);
    end
    #1;
    rst_n = 1'b0;
    valid_a = 1'b1; id_a = 5'd2;
    #1;
    n_tests++;
    if (valid_c !== 1'b0 || payload_c !== 128'd0 || id_c !== 6'd0 || qos_c !== 2'd0 ||
        ready_a !== 1'b0 || ready_b !== 1'b0 || err_release !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: valid=%b id=%h qos=%h ra=%b rb=%b err=%b, required all 0",
               valid_c, id_c, qos_c, ready_a, ready_b, err_release);
    end
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    next_cycle();
    @(negedge clk);
    n_tests++;
    if (valid_c !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_drop: valid_c=%b after reset, required 0", valid_c);
    end
  endtask

  task automatic test_random();
    bit           mo [64];
    int           ms [2];
    int           mptr, mgap, w, start;
    bit           mhave, merr, vc, acc, conf, can, e0, e1, rr, grant, f0, f1, found;
    logic [127:0] mpay;
    logic [5:0]   mid, ia, ib;
    logic [1:0]   mqos;
    bit           exp_ra, exp_rb;
    do_reset();
    for (int i = 0; i < 64; i++) mo[i] = 1'b0;
    ms[0] = 0; ms[1] = 0; mptr = 0; mgap = 0; mhave = 1'b0; merr = 1'b0;
    mpay = '0; mid = '0; mqos = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      next_cycle();
      valid_a = ($urandom_range(0, 9) < 7);
      id_a = 5'($urandom_range(0, 7)); qos_a = 2'($urandom_range(0, 3));
      payload_a = {$urandom, $urandom, $urandom, $urandom};
      valid_b = ($urandom_range(0, 9) < 7);
      id_b = 5'($urandom_range(0, 7)); qos_b = 2'($urandom_range(0, 3));
      payload_b = {$urandom, $urandom, $urandom, $urandom};
      ready_c = ($urandom_range(0, 3) != 0);
      conflict_c = ($urandom_range(0, 6) == 0);
      release_c = ($urandom_range(0, 2) == 0);
      releaseid_c = 6'($urandom_range(0, 63));
      if (release_c && $urandom_range(0, 49) != 0) begin
        found = 1'b0;
        start = $urandom_range(0, 63);
        for (int j = 0; j < 64; j++) begin
          if (!found && mo[(start + j) % 64]) begin
            found = 1'b1;
            releaseid_c = 6'((start + j) % 64);
          end
        end
        release_c = found;
      end
      @(negedge clk);
      vc   = mhave && (mgap == 0);
      acc  = vc && ready_c && !conflict_c;
      conf = vc && ready_c && conflict_c;
      can  = (mgap == 0) && (!vc || acc);
      ia = {1'b0, id_a};
      ib = {1'b1, id_b};
      e0 = valid_a && !mo[ia] && !(vc && mid == ia);
      e1 = valid_b && !mo[ib] && !(vc && mid == ib);
      rr = 1'b0;
      w = 0;
      if (e0 && e1) begin
        f0 = (ms[0] == STARVE_MAX);
        f1 = (ms[1] == STARVE_MAX);
        if (f0 != f1) w = f1 ? 1 : 0;
        else if (!f0 && qos_a != qos_b) w = (qos_b > qos_a) ? 1 : 0;
        else begin w = mptr; rr = 1'b1; end
      end else begin
        w = e1 ? 1 : 0;
      end
      grant  = can && (e0 || e1);
      exp_ra = grant && (w == 0);
      exp_rb = grant && (w == 1);
      n_tests++;
      if (ready_a !== exp_ra || ready_b !== exp_rb || valid_c !== vc || err_release !== merr) begin
        n_fail++;
        $display("FAIL rand_ctrl cyc %0d: ra=%b rb=%b vc=%b err=%b, required %b %b %b %b",
                 cyc, ready_a, ready_b, valid_c, err_release, exp_ra, exp_rb, vc, merr);
      end
      if (vc) begin
        n_tests++;
        if (id_c !== mid || qos_c !== mqos || payload_c !== mpay) begin
          n_fail++;
          $display("FAIL rand_beat cyc %0d: id=%h qos=%h payload=%h, required %h %h %h",
                   cyc, id_c, qos_c, payload_c, mid, mqos, mpay);
        end
      end
      if (release_c) begin
        if (!mo[releaseid_c]) merr = 1'b1;
        else mo[releaseid_c] = 1'b0;
      end
      if (acc) mo[mid] = 1'b1;
      if (grant) begin
        ms[w] = 0;
        if ((w == 0 ? e1 : e0) && ms[1 - w] < STARVE_MAX) ms[1 - w]++;
        if (rr) mptr = 1 - w;
        mhave = 1'b1;
        mid  = (w == 0) ? ia : ib;
        mqos = (w == 0) ? qos_a : qos_b;
        mpay = (w == 0) ? payload_a : payload_b;
      end else if (acc) begin
        mhave = 1'b0;
      end
      if (conf) mgap = RETRY_GAP;
      else if (mgap > 0) mgap--;
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_a();
    test_starvation();
    test_tie_alternate();
    test_conflict();
    test_err_and_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
